inv_chain_pulse_ctrl: RTL
=========================

Name: inv_chain_pulse_ctrl

Overview:
- Stimulus sequencer and measurement controller for an inverter-chain delay testbed.
- Drives the chain input with a programmable train of pulses (high width, low width, count).
- Synchronizes the chain output, then counts its transitions and measures first-edge latency in clock cycles.
- Sits between the test register/host interface and the chain's input/output pins.

Parameters:
- CNT_W, 16, width of the pulse-width, gap, timeout and latency counters.
- NP_W, 8, width of the pulse-count field.
- EDGE_W, 10, width of the output edge counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- pulse_high  in  CNT_W  cycles chain_in is held at 1 per pulse; 0 is treated as 1.
- pulse_low  in  CNT_W  cycles chain_in is held at 0 after each pulse; 0 is treated as 1.
- num_pulses  in  NP_W  pulses per run.
- drain_cycles  in  CNT_W  observation window after the last pulse.
- chain_out  in  1  chain output; asynchronous to clk.
- chain_in  out  1  chain input drive, registered.
- busy  out  1  high from the cycle after an accepted start until the cycle done is asserted.
- done  out  1  one-cycle strobe at the end of a run.
- edge_cnt  out  EDGE_W  synchronized chain_out transitions seen during the run; saturating.
- first_lat  out  CNT_W  cycles from the first chain_in rise to the first synchronized chain_out edge.
- no_edge  out  1  no chain_out edge seen during the run.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; chain_in=0, busy=0, done=0, edge_cnt=0, first_lat=0, no_edge=0.
  - Synchronizer flops cleared to 0.
- Synchronizer: two flops, chain_out -> s1 -> s2. An edge is defined as s2 != s2_d (one more flop).
- States: IDLE, HIGH, LOW, DRAIN, FIN.
- IDLE:
  - chain_in=0.
  - On start=1, latch all config inputs; clear edge_cnt, first_lat and no_edge; set the internal lat_armed flag=0.
  - If num_pulses==0, go to FIN. Otherwise go to HIGH and load the width counter with max(pulse_high,1).
  - Config changes after start have no effect until the next run.
- HIGH:
  - chain_in=1, taking the value on the first cycle in HIGH.
  - Width counter decrements each cycle; leave when it reaches 1, so HIGH lasts exactly max(pulse_high,1) cycles.
  - Then go to LOW, loading max(pulse_low,1).
- LOW:
  - chain_in=0 for exactly max(pulse_low,1) cycles.
  - At exit, decrement the pulse counter. If it is not yet 0, go to HIGH; otherwise go to DRAIN, loading drain_cycles.
- DRAIN:
  - chain_in=0. Stay drain_cycles cycles (0 means exit after 1 cycle), then go to FIN.
- FIN:
  - done=1 for exactly this one cycle; busy=0 in this cycle; no_edge = (edge_cnt==0).
  - Next state is IDLE.
- Edge counting:
  - Active in HIGH, LOW and DRAIN only.
  - edge_cnt += 1 per detected edge; saturates at all ones.
- Latency:
  - A latency counter starts at 0 on the first HIGH cycle of the run and increments every cycle thereafter.
  - On the first detected edge with lat_armed=0: first_lat = counter value and lat_armed=1.
  - If no edge occurs by FIN, first_lat = all ones.
  - The latency counter saturates at all ones.
  - Measured latency includes the 3-cycle detection pipeline; software subtracts it.
- Output hold: edge_cnt, first_lat and no_edge hold their values after FIN until the next accepted start.
- start outside IDLE (including in FIN) is ignored; no queuing.
- Reset mid-run returns the block immediately to IDLE with chain_in=0. No done strobe is issued.
- Simultaneous last LOW cycle and an edge: the edge is counted. Counting continues through DRAIN.

Test Plan:
- Single pulse: pulse_high=4, pulse_low=4, num_pulses=1, drain_cycles=10; chain_out = chain_in delayed by 2 cycles.
  - Required: chain_in high for exactly 4 cycles; done 19 cycles after start accepted (4+4+10+1); edge_cnt=2; first_lat=5; no_edge=0.
- Train: pulse_high=2, pulse_low=3, num_pulses=5, drain_cycles=8; chain_out = chain_in delayed by 1 cycle.
  - Required: chain_in shows 5 pulses on a 5-cycle period; edge_cnt=10.
- Zero config: num_pulses=0 -> chain_in never rises; done exactly 1 cycle after start; edge_cnt=0; no_edge=1; first_lat=0.
- Width clamp and stuck output: pulse_high=0, pulse_low=0, num_pulses=3, drain_cycles=0; chain_out tied to 0.
  - Required: pulses are 1 cycle high and 1 cycle low; no_edge=1; first_lat=0xFFFF.
- Robustness: start pulsed in mid-HIGH is ignored. rst_n dropped during LOW of a 4-pulse run -> chain_in=0, busy=0 asynchronously, no done.
  - After release, a new run completes normally.
- Saturation: pulse_high=1, pulse_low=1, num_pulses=255, EDGE_W=8; chain_out follows chain_in -> edge_cnt=255 (saturated), not wrapped.

Source files
------------

// File: rtl/inv_chain_pulse_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : inv_chain_pulse_ctrl_if
//  Purpose  : Bundles the host-side configuration/handshake and the chain
//             pins of the inverter-chain pulse controller.
//  Signals  : start, pulse_high, pulse_low, num_pulses, drain_cycles,
//             chain_out                  (master -> slave)
//             chain_in, busy, done, edge_cnt, first_lat, no_edge
//                                         (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface inv_chain_pulse_ctrl_if #(
  parameter int CNT_W  = 16,
  parameter int NP_W   = 8,
  parameter int EDGE_W = 10
);
  logic              start;
  logic [CNT_W-1:0]  pulse_high;
  logic [CNT_W-1:0]  pulse_low;
  logic [NP_W-1:0]   num_pulses;
  logic [CNT_W-1:0]  drain_cycles;
  logic              chain_out;
  logic              chain_in;
  logic              busy;
  logic              done;
  logic [EDGE_W-1:0] edge_cnt;
  logic [CNT_W-1:0]  first_lat;
  logic              no_edge;

  modport master (
    output start, pulse_high, pulse_low, num_pulses, drain_cycles, chain_out,
    input  chain_in, busy, done, edge_cnt, first_lat, no_edge
  );

  modport slave (
    input  start, pulse_high, pulse_low, num_pulses, drain_cycles, chain_out,
    output chain_in, busy, done, edge_cnt, first_lat, no_edge
  );
endinterface
`default_nettype wire

// File: rtl/inv_chain_pulse_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : inv_chain_pulse_ctrl
//  Purpose  : Drives an inverter chain with a programmable pulse train and
//             measures the chain response: synchronized output edge count
//             and first-edge latency, both in clk cycles.
//  Ports    : clk        - single clock
//             rst_n      - asynchronous active-low reset
//             bus.slave  - start/config inputs, chain_out pin (in);
//                          chain_in pin, busy, done, edge_cnt, first_lat,
//                          no_edge (out)
//  Revision : 1.0  initial release
// ============================================================================
module inv_chain_pulse_ctrl #(
  parameter int CNT_W  = 16,
  parameter int NP_W   = 8,
  parameter int EDGE_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inv_chain_pulse_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HIGH  = 3'd1,
    S_LOW   = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [NP_W-1:0]   NP_ONE   = NP_W'(1);
  localparam logic [NP_W-1:0]   NP_ZERO  = '0;
  localparam logic [EDGE_W-1:0] EDGE_MAX = {EDGE_W{1'b1}};

  // Zero widths behave as one cycle.
  function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_ONE : v;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;       // cycles left in current phase
  logic [NP_W-1:0]   pcnt_q, pcnt_d;       // pulses left in this run
  logic [CNT_W-1:0]  ph_q, ph_d;           // latched configuration
  logic [CNT_W-1:0]  pl_q, pl_d;
  logic [CNT_W-1:0]  dr_q, dr_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              lat_armed_q, lat_armed_d;
  logic              chain_in_q, chain_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]  first_lat_q, first_lat_d;
  logic              no_edge_q, no_edge_d;
  logic              in_run;

  // chain_out synchronizer plus edge detector. The edge pulse is registered
  // so the path from a chain_out change to a counted edge is three flops.
  logic s1_q, s2_q, s2d_q, edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s2d_q  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= bus.chain_out;
      s2_q   <= s1_q;
      s2d_q  <= s2_q;
      edge_q <= s2_q ^ s2d_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      pcnt_q      <= '0;
      ph_q        <= '0;
      pl_q        <= '0;
      dr_q        <= '0;
      lat_cnt_q   <= '0;
      lat_armed_q <= 1'b0;
      chain_in_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      edge_cnt_q  <= '0;
      first_lat_q <= '0;
      no_edge_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      pcnt_q      <= pcnt_d;
      ph_q        <= ph_d;
      pl_q        <= pl_d;
      dr_q        <= dr_d;
      lat_cnt_q   <= lat_cnt_d;
      lat_armed_q <= lat_armed_d;
      chain_in_q  <= chain_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      edge_cnt_q  <= edge_cnt_d;
      first_lat_q <= first_lat_d;
      no_edge_q   <= no_edge_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    pcnt_d      = pcnt_q;
    ph_d        = ph_q;
    pl_d        = pl_q;
    dr_d        = dr_q;
    lat_cnt_d   = lat_cnt_q;
    lat_armed_d = lat_armed_q;
    edge_cnt_d  = edge_cnt_q;
    first_lat_d = first_lat_q;
    no_edge_d   = no_edge_q;
    in_run      = (state_q == S_HIGH) || (state_q == S_LOW) ||
                  (state_q == S_DRAIN);

    // Measurement runs through HIGH, LOW and DRAIN, so an edge landing on
    // the last cycle of a phase is still counted.
    if (in_run) begin
      if (edge_q) begin
        if (edge_cnt_q != EDGE_MAX) begin
          edge_cnt_d = edge_cnt_q + 1'b1;
        end
        if (!lat_armed_q) begin
          first_lat_d = lat_cnt_q;
          lat_armed_d = 1'b1;
        end
      end
      if (lat_cnt_q != CNT_MAX) begin
        lat_cnt_d = lat_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ph_d        = bus.pulse_high;
          pl_d        = bus.pulse_low;
          dr_d        = bus.drain_cycles;
          pcnt_d      = bus.num_pulses;
          edge_cnt_d  = '0;
          first_lat_d = '0;
          no_edge_d   = 1'b0;
          lat_armed_d = 1'b0;
          lat_cnt_d   = '0;
          if (bus.num_pulses == NP_ZERO) begin
            state_d = S_FIN;
          end else begin
            state_d = S_HIGH;
            wcnt_d  = clamp1(bus.pulse_high);
          end
        end
      end
      S_HIGH: begin
        if (wcnt_q <= CNT_ONE) begin
          state_d = S_LOW;
          wcnt_d  = clamp1(pl_q);
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_LOW: begin
        if (wcnt_q <= CNT_ONE) begin
          pcnt_d = pcnt_q - 1'b1;
          if (pcnt_q == NP_ONE) begin
            state_d = S_DRAIN;
            wcnt_d  = dr_q;
          end else begin
            state_d = S_HIGH;
            wcnt_d  = clamp1(ph_q);
          end
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_DRAIN: begin
        // A drain of 0 still spends one cycle here.
        if (wcnt_q <= CNT_ONE) begin
          state_d = S_FIN;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Results are final in the done cycle. A run that pulsed but saw no
    // edge reports all-ones latency; a zero-pulse run keeps latency at 0.
    if (state_d == S_FIN) begin
      no_edge_d = (edge_cnt_d == '0);
      if (!lat_armed_d && (state_q == S_DRAIN)) begin
        first_lat_d = CNT_MAX;
      end
    end

    // Outputs are registered from the next state so they line up with it.
    chain_in_d = (state_d == S_HIGH);
    busy_d     = (state_d == S_HIGH) || (state_d == S_LOW) ||
                 (state_d == S_DRAIN);
    done_d     = (state_d == S_FIN);
  end

  assign bus.chain_in  = chain_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.edge_cnt  = edge_cnt_q;
  assign bus.first_lat = first_lat_q;
  assign bus.no_edge   = no_edge_q;

endmodule
`default_nettype wire
